// File: rtl/weight_fetch_scheduler_if.sv
// ---------------------------------------------------------------------------
// weight_fetch_scheduler_if
//
// Purpose: bundles the descriptor handshake, PE backpressure, the read-master
// control side (address / read enable / data valid), the return-path markers
// and the status flags of the weight fetch scheduler.
//
// Signal summary:
//   cfg_valid, cfg_ready        descriptor handshake
//   cfg_base_addr               first word address of the weight block
//   cfg_num_beats               beats per pass
//   cfg_num_passes              times the block is fetched
//   pe_ready                    PE array can absorb more weights
//   rm_addr, rm_read_en         read request to the read master
//   rm_data_valid               one read beat returned this cycle
//   rx_last_beat, rx_pass_idx   pass boundary markers on the return path
//   busy, done, err_unexpected  status
//
// Modports:
//   slave  - the scheduler itself
//   master - the surrounding layer controller / read master / PE side
// ---------------------------------------------------------------------------
interface weight_fetch_scheduler_if #(
    parameter int ADDR_W = 17,
    parameter int LEN_W  = 12,
    parameter int PASS_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [LEN_W-1:0]  cfg_num_beats;
    logic [PASS_W-1:0] cfg_num_passes;
    logic              pe_ready;
    logic [ADDR_W-1:0] rm_addr;
    logic              rm_read_en;
    logic              rm_data_valid;
    logic              rx_last_beat;
    logic [PASS_W-1:0] rx_pass_idx;
    logic              busy;
    logic              done;
    logic              err_unexpected;

    modport slave (
        input  cfg_valid, cfg_base_addr, cfg_num_beats, cfg_num_passes,
        input  pe_ready, rm_data_valid,
        output cfg_ready, rm_addr, rm_read_en, rx_last_beat, rx_pass_idx,
        output busy, done, err_unexpected
    );

    modport master (
        output cfg_valid, cfg_base_addr, cfg_num_beats, cfg_num_passes,
        output pe_ready, rm_data_valid,
        input  cfg_ready, rm_addr, rm_read_en, rx_last_beat, rx_pass_idx,
        input  busy, done, err_unexpected
    );
endinterface

// File: rtl/weight_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// weight_fetch_scheduler
//
// Purpose: sequences the on-chip weight read master for one weight block per
// command. A descriptor (base, beats per pass, passes) is accepted in IDLE;
// the block is then read once per pass, one 1024-bit read per beat, with the
// number of in-flight reads capped at MAX_OUTST and issue paused while the PE
// array deasserts pe_ready. Returning beats are counted so the last beat of
// every pass is flagged together with the pass index it belongs to.
//
// Ports:
//   clk     clock
//   rst_n   asynchronous, active-low reset
//   bus_io  weight_fetch_scheduler_if.slave (handshake, read master control,
//           return markers, status)
// ---------------------------------------------------------------------------
module weight_fetch_scheduler #(
    parameter int ADDR_W    = 17,
    parameter int LEN_W     = 12,
    parameter int PASS_W    = 8,
    parameter int MAX_OUTST = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    weight_fetch_scheduler_if.slave bus_io
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [LEN_W-1:0]  beats_q,    beats_d;
    logic [PASS_W-1:0] passes_q,   passes_d;
    logic [LEN_W-1:0]  beatCnt_q,  beatCnt_d;
    logic [PASS_W-1:0] passCnt_q,  passCnt_d;
    logic [LEN_W-1:0]  rxBeat_q,   rxBeat_d;
    logic [PASS_W-1:0] rxPass_q,   rxPass_d;
    logic [OUT_W-1:0]  outst_q,    outst_d;
    logic [ADDR_W-1:0] rmAddr_q,   rmAddr_d;
    logic              rmReadEn_q, rmReadEn_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    logic accept;
    logic issue;
    logic retValid;
    logic lastBeat;
    logic lastPass;
    logic rxLast;

    // The done pulse is registered one cycle after the DONE state, so the
    // scheduler refuses a new descriptor until that pulse has been seen.
    assign accept   = (state_q == IDLE) && !done_q && bus_io.cfg_valid;

    // The in-flight check uses outst_q before any same-cycle return, so the
    // limit is never exceeded even if a return coincides with an issue.
    assign issue    = (state_q == ISSUE) && bus_io.pe_ready &&
                      (outst_q < OUT_W'(MAX_OUTST));

    // A return with nothing outstanding is an error and must not disturb
    // any of the return-path accounting.
    assign retValid = bus_io.rm_data_valid && (outst_q != '0);

    assign lastBeat = (beatCnt_q == beats_q - LEN_W'(1));
    assign lastPass = (passCnt_q == passes_q - PASS_W'(1));
    assign rxLast   = retValid && (rxBeat_q == beats_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beats_d    = beats_q;
        passes_d   = passes_q;
        beatCnt_d  = beatCnt_q;
        passCnt_d  = passCnt_q;
        rxBeat_d   = rxBeat_q;
        rxPass_d   = rxPass_q;
        rmAddr_d   = rmAddr_q;
        rmReadEn_d = 1'b0;
        done_d     = (state_q == DONE);
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d    = bus_io.cfg_base_addr;
                    beats_d   = bus_io.cfg_num_beats;
                    passes_d  = bus_io.cfg_num_passes;
                    beatCnt_d = '0;
                    passCnt_d = '0;
                    rxBeat_d  = '0;
                    rxPass_d  = '0;
                    err_d     = 1'b0;
                    if ((bus_io.cfg_num_beats == '0) || (bus_io.cfg_num_passes == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    rmReadEn_d = 1'b1;
                    rmAddr_d   = base_q + ADDR_W'(beatCnt_q);
                    if (lastBeat) begin
                        beatCnt_d = '0;
                        passCnt_d = passCnt_q + PASS_W'(1);
                        if (lastPass) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        beatCnt_d = beatCnt_q + LEN_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (retValid) begin
            if (rxLast) begin
                rxBeat_d = '0;
                rxPass_d = rxPass_q + PASS_W'(1);
            end else begin
                rxBeat_d = rxBeat_q + LEN_W'(1);
            end
        end

        if (bus_io.rm_data_valid && (outst_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // An issue and a return in the same cycle cancel out.
    assign outst_d = outst_q + OUT_W'(issue) - OUT_W'(retValid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            beats_q    <= '0;
            passes_q   <= '0;
            beatCnt_q  <= '0;
            passCnt_q  <= '0;
            rxBeat_q   <= '0;
            rxPass_q   <= '0;
            outst_q    <= '0;
            rmAddr_q   <= '0;
            rmReadEn_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            beats_q    <= beats_d;
            passes_q   <= passes_d;
            beatCnt_q  <= beatCnt_d;
            passCnt_q  <= passCnt_d;
            rxBeat_q   <= rxBeat_d;
            rxPass_q   <= rxPass_d;
            outst_q    <= outst_d;
            rmAddr_q   <= rmAddr_d;
            rmReadEn_q <= rmReadEn_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus_io.cfg_ready      = (state_q == IDLE) && !done_q;
    assign bus_io.busy           = (state_q != IDLE) || done_q;
    assign bus_io.done           = done_q;
    assign bus_io.rm_addr        = rmAddr_q;
    assign bus_io.rm_read_en     = rmReadEn_q;
    assign bus_io.rx_last_beat   = rxLast;
    assign bus_io.rx_pass_idx    = rxPass_q;
    assign bus_io.err_unexpected = err_q;

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch_scheduler
//
// Purpose: directed testbench for weight_fetch_scheduler. A small read-master
// stand-in either returns each read a fixed two cycles later or follows a
// per-cycle return mask; pe_ready follows a per-cycle low mask. Every cycle
// the issued addresses, return markers and done pulses are recorded and then
// compared against hand-computed constants.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_weight_fetch_scheduler;

    localparam int ADDR_W    = 17;
    localparam int LEN_W     = 12;
    localparam int PASS_W    = 8;
    localparam int MAX_OUTST = 4;

    logic clk = 1'b0;
    logic rst_n;

    weight_fetch_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .PASS_W(PASS_W)) w ();

    weight_fetch_scheduler #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .PASS_W   (PASS_W),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(w)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          acceptCyc   = 1 << 20;
    int          retNum      = 0;
    int          doneCnt     = 0;
    int          doneCyc     = -1;
    int          addrQ[$];
    int          issueCyc[$];
    int          lastRetQ[$];
    int          passAtRet[$];
    logic [63:0] retMask     = '0;
    logic [63:0] peLowMask   = '0;
    bit          autoRet     = 1'b1;
    logic [7:0]  retPipe     = '0;
    logic        enTrace[64];
    int          addrTrace[64];
    int          exp2[6]     = '{32'h100, 32'h101, 32'h102, 32'h100, 32'h101, 32'h102};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // One clock cycle: drive the reactive inputs just after the falling edge,
    // let them settle, then record what the DUT shows for this cycle.
    task automatic cycle();
        int rel;
        @(negedge clk);
        cyc++;
        rel = cyc - acceptCyc;
        retPipe = {retPipe[6:0], w.rm_read_en};
        if (autoRet) begin
            w.rm_data_valid = retPipe[2];
        end else begin
            w.rm_data_valid = (rel >= 0 && rel < 64) ? retMask[rel] : 1'b0;
        end
        w.pe_ready = (rel >= 0 && rel < 64) ? !peLowMask[rel] : 1'b1;
        #1;
        if (rel >= 0 && rel < 64) begin
            enTrace[rel]   = w.rm_read_en;
            addrTrace[rel] = int'(w.rm_addr);
        end
        if (w.rm_read_en) begin
            addrQ.push_back(int'(w.rm_addr));
            issueCyc.push_back(cyc);
        end
        if (w.rm_data_valid) begin
            retNum++;
            passAtRet.push_back(int'(w.rx_pass_idx));
        end
        if (w.rx_last_beat) lastRetQ.push_back(retNum);
        if (w.done) begin
            doneCnt++;
            doneCyc = cyc;
        end
    endtask

    // Presents one descriptor for a single cycle; that cycle is rel 0.
    task automatic applyStimulus(input logic [16:0] base, input logic [11:0] beats,
                                 input logic [7:0] passes);
        addrQ.delete();
        issueCyc.delete();
        lastRetQ.delete();
        passAtRet.delete();
        retNum  = 0;
        doneCnt = 0;
        doneCyc = -1;
        retPipe = '0;
        acceptCyc = cyc + 1;
        cycle();
        checkOutput("cfg_ready before accept", w.cfg_ready, 1);
        w.cfg_valid      = 1'b1;
        w.cfg_base_addr  = base;
        w.cfg_num_beats  = beats;
        w.cfg_num_passes = passes;
        cycle();
        w.cfg_valid = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (doneCnt == 0 && n < limit) begin
            cycle();
            n++;
        end
        checkOutput("done seen", doneCnt, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        rst_n            = 1'b0;
        w.cfg_valid      = 1'b0;
        w.cfg_base_addr  = '0;
        w.cfg_num_beats  = '0;
        w.cfg_num_passes = '0;
        w.pe_ready       = 1'b1;
        w.rm_data_valid  = 1'b0;

        // Reset state
        repeat (2) cycle();
        checkOutput("reset rm_read_en", w.rm_read_en, 0);
        checkOutput("reset rm_addr", w.rm_addr, 0);
        checkOutput("reset busy", w.busy, 0);
        checkOutput("reset done", w.done, 0);
        checkOutput("reset err", w.err_unexpected, 0);
        checkOutput("reset pass_idx", w.rx_pass_idx, 0);
        rst_n = 1'b1;
        cycle();
        checkOutput("reset cfg_ready", w.cfg_ready, 1);

        // Basic fetch
        $display("[TB] basic fetch");
        autoRet = 1'b1; retMask = '0; peLowMask = '0;
        applyStimulus(17'h100, 12'd4, 8'd1);
        checkOutput("basic busy after accept", w.busy, 1);
        checkOutput("basic cfg_ready busy", w.cfg_ready, 0);
        waitDone(60);
        checkOutput("basic done cycle", doneCyc - acceptCyc, 10);
        checkOutput("basic busy in done", w.busy, 1);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("basic addr %0d", i), qAt(addrQ, i), 32'h100 + i);
        checkOutput("basic consecutive", qAt(issueCyc, 3) - qAt(issueCyc, 0), 3);
        checkOutput("basic last beat count", lastRetQ.size(), 1);
        checkOutput("basic last beat index", qAt(lastRetQ, 0), 4);
        cycle();
        checkOutput("basic busy after done", w.busy, 0);
        checkOutput("basic done cleared", w.done, 0);
        repeat (3) cycle();
        checkOutput("basic done once", doneCnt, 1);
        checkOutput("basic issue count", addrQ.size(), 4);
        checkOutput("basic pass_idx end", w.rx_pass_idx, 1);

        // Multi-pass
        $display("[TB] multi-pass");
        applyStimulus(17'h100, 12'd3, 8'd2);
        waitDone(60);
        repeat (2) cycle();
        checkOutput("multi issue count", addrQ.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("multi addr %0d", i), qAt(addrQ, i), exp2[i]);
        checkOutput("multi last count", lastRetQ.size(), 2);
        checkOutput("multi last 0", qAt(lastRetQ, 0), 3);
        checkOutput("multi last 1", qAt(lastRetQ, 1), 6);
        checkOutput("multi pass ret1", qAt(passAtRet, 0), 0);
        checkOutput("multi pass ret4", qAt(passAtRet, 3), 1);
        checkOutput("multi pass end", w.rx_pass_idx, 2);

        // Outstanding limit
        $display("[TB] outstanding limit");
        autoRet = 1'b0;
        retMask = 64'h1_FC10_0000;
        applyStimulus(17'h400, 12'd8, 8'd1);
        while (cyc - acceptCyc < 19) cycle();
        checkOutput("outst stall count", addrQ.size(), 4);
        checkOutput("outst 4th issue", qAt(issueCyc, 3) - acceptCyc, 5);
        waitDone(80);
        checkOutput("outst 5th issue", qAt(issueCyc, 4) - acceptCyc, 22);
        checkOutput("outst 6th issue", qAt(issueCyc, 5) - acceptCyc, 28);
        checkOutput("outst 7th issue", qAt(issueCyc, 6) - acceptCyc, 29);
        checkOutput("outst 8th issue", qAt(issueCyc, 7) - acceptCyc, 30);
        checkOutput("outst last addr", qAt(addrQ, 7), 32'h407);
        checkOutput("outst done cycle", doneCyc - acceptCyc, 35);
        checkOutput("outst no err", w.err_unexpected, 0);
        retMask = '0;

        // Backpressure
        $display("[TB] backpressure");
        autoRet = 1'b1;
        peLowMask = 64'hF8;
        applyStimulus(17'h200, 12'd4, 8'd1);
        waitDone(60);
        cnt = 0;
        for (int r = 4; r <= 8; r++) cnt += int'(enTrace[r]);
        checkOutput("bp read_en during pause", cnt, 0);
        checkOutput("bp addr held", addrTrace[6], 32'h201);
        checkOutput("bp 3rd issue cycle", qAt(issueCyc, 2) - acceptCyc, 9);
        checkOutput("bp 3rd addr", qAt(addrQ, 2), 32'h202);
        checkOutput("bp 4th addr", qAt(addrQ, 3), 32'h203);
        peLowMask = '0;

        // Zero-length commands
        $display("[TB] zero length");
        applyStimulus(17'h10, 12'd0, 8'd3);
        waitDone(10);
        checkOutput("beats0 done cycle", doneCyc - acceptCyc, 2);
        repeat (2) cycle();
        checkOutput("beats0 no reads", addrQ.size(), 0);
        applyStimulus(17'h10, 12'd5, 8'd0);
        waitDone(10);
        checkOutput("passes0 done cycle", doneCyc - acceptCyc, 2);
        checkOutput("passes0 no reads", addrQ.size(), 0);

        // Address wrap
        $display("[TB] address wrap");
        applyStimulus(17'h1FFFF, 12'd2, 8'd1);
        waitDone(40);
        checkOutput("wrap addr 0", qAt(addrQ, 0), 32'h1FFFF);
        checkOutput("wrap addr 1", qAt(addrQ, 1), 32'h0);

        // Unexpected return in IDLE
        $display("[TB] unexpected return");
        repeat (2) cycle();
        autoRet = 1'b0;
        retMask = 64'h2;
        acceptCyc = cyc + 1;
        repeat (3) cycle();
        checkOutput("err set in idle", w.err_unexpected, 1);
        repeat (3) cycle();
        checkOutput("err sticky", w.err_unexpected, 1);
        checkOutput("err idle busy", w.busy, 0);
        retMask = '0;
        applyStimulus(17'h10, 12'd0, 8'd1);
        checkOutput("err cleared by accept", w.err_unexpected, 0);
        waitDone(10);

        // Reset mid-ISSUE
        $display("[TB] reset mid-issue");
        applyStimulus(17'h300, 12'd8, 8'd4);
        cycle();
        cycle();
        checkOutput("rst pre read_en", w.rm_read_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst read_en", w.rm_read_en, 0);
        checkOutput("rst addr", w.rm_addr, 0);
        checkOutput("rst busy", w.busy, 0);
        checkOutput("rst done", w.done, 0);
        checkOutput("rst pass_idx", w.rx_pass_idx, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        checkOutput("rst cfg_ready", w.cfg_ready, 1);
        retMask = 64'h1;
        acceptCyc = cyc + 1;
        repeat (2) cycle();
        checkOutput("rst late return err", w.err_unexpected, 1);
        retMask = '0;
        autoRet = 1'b1;
        applyStimulus(17'h40, 12'd2, 8'd1);
        waitDone(40);
        checkOutput("post-rst addr 0", qAt(addrQ, 0), 32'h40);
        checkOutput("post-rst addr 1", qAt(addrQ, 1), 32'h41);
        checkOutput("post-rst err clear", w.err_unexpected, 0);

        repeat (2) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weight_fetch_scheduler.md
Name: weight_fetch_scheduler

Overview:
- Sequences the on-chip weight read master for one weight block per command.
- Accepts a descriptor: base address, beats per pass, number of passes. Issues one 1024-bit read per beat and repeats the block once per pass, which serves one output tile per pass.
- Limits in-flight reads, pauses issue on PE-array backpressure, and marks pass boundaries on the return path.
- Sits between the layer controller and the read master's control-side interface (address, read enable, data valid).

Parameters:
- ADDR_W, 17, word address width to the read master.
- LEN_W, 12, width of beats-per-pass field.
- PASS_W, 8, width of pass-count field.
- MAX_OUTST, 4, maximum reads issued but not yet returned (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_valid  in  1  descriptor valid
- cfg_ready  out  1  scheduler can accept a descriptor (high only in IDLE)
- cfg_base_addr  in  ADDR_W  first word address of the weight block
- cfg_num_beats  in  LEN_W  beats per pass
- cfg_num_passes  in  PASS_W  times the block is fetched
- pe_ready  in  1  PE array can absorb more weights; low pauses issue
- rm_addr  out  ADDR_W  read address to the read master
- rm_read_en  out  1  one read request at rm_addr this cycle
- rm_data_valid  in  1  one read beat returned this cycle
- rx_last_beat  out  1  pulse together with the rm_data_valid of the final beat of each pass
- rx_pass_idx  out  PASS_W  pass index of the beat currently returning
- busy  out  1  high from descriptor accept until the done cycle, inclusive
- done  out  1  one-cycle pulse when the command completes
- err_unexpected  out  1  sticky: rm_data_valid seen with zero reads outstanding

Behaviour:
- Reset (async assert): state=IDLE; all counters 0; rm_read_en=0, rm_addr=0, done=0, busy=0, err_unexpected=0, rx_last_beat=0, rx_pass_idx=0. cfg_ready=1 immediately after reset.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch base, beats and passes; clear the issue and return counters; clear err_unexpected.
  - If beats==0 or passes==0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Issue condition at a clock edge: pe_ready=1 and outst < MAX_OUTST.
  - When the condition holds, the next cycle has rm_read_en=1 and rm_addr = (base + beat_cnt) mod 2^ADDR_W. Outputs are registered, so issue latency is 1 cycle.
  - When the condition fails, rm_read_en=0 next cycle and rm_addr holds its value.
  - After each issue, beat_cnt increments. On the last beat of a pass, beat_cnt wraps to 0 and pass_cnt increments.
  - On issuing the final beat of the final pass, go to DRAIN.
- outst counter:
  - +1 on each issue, -1 on each rm_data_valid, unchanged when both occur in the same cycle.
  - The issue check uses outst before the same-cycle decrement. This is conservative and never exceeds MAX_OUTST.
- DRAIN: no issue (rm_read_en=0); when outst==0, go to DONE.
- DONE: done=1 for exactly one cycle, busy still high; then go to IDLE.
- Return path:
  - rx_beat counts rm_data_valid pulses.
  - rx_last_beat is combinational: rm_data_valid && rx_beat==beats-1.
  - On that beat, rx_beat wraps to 0 and rx_pass_idx increments. rx_pass_idx holds its final value until the next accept.
- rm_data_valid with outst==0: set err_unexpected and leave the counters unchanged. This applies in every state, including a late return after reset.
- pe_ready low mid-pass: issue stops and rm_addr holds; outstanding returns still complete. Issue resumes at the same beat_cnt.
- Address overflow: the sum wraps modulo 2^ADDR_W with no error.
- cfg_valid outside IDLE: ignored; cfg_ready=0.
- Reset mid-command: returns to IDLE at once and discards all in-flight accounting.

Test Plan:
- Basic fetch: base=0x100, beats=4, passes=1, pe_ready=1, data_valid 2 cycles after each read.
  - rm_addr 0x100..0x103 on 4 consecutive rm_read_en cycles.
  - rx_last_beat on the 4th return; done exactly once; busy low the cycle after done.
- Multi-pass: beats=3, passes=2.
  - Address sequence 0x100,0x101,0x102,0x100,0x101,0x102.
  - rx_last_beat on returns 3 and 6; rx_pass_idx 0 then 1 then 2.
- Outstanding limit: MAX_OUTST=4, beats=8, no returns until cycle 20.
  - Exactly 4 rm_read_en pulses, then stall.
  - Each later return permits exactly one new issue; a same-cycle issue and return keeps outst constant.
- Backpressure: pe_ready low after the 2nd issue for 5 cycles.
  - rm_read_en=0 and rm_addr held during the pause.
  - The 3rd issue uses base+2 after pe_ready rises.
- Edge cases:
  - beats=0: done pulse 2 cycles after accept with no rm_read_en.
  - base=0x1FFFF, beats=2: addresses 0x1FFFF then 0x00000.
- Error and reset:
  - rm_data_valid in IDLE sets err_unexpected, which stays set until the next accept.
  - rst_n low mid-ISSUE clears all outputs asynchronously; cfg_ready=1 after release.
